// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer for the calculator datapath.
// Ports: clk/rst (async high); key_valid/key_code key events in;
//   alu_a/alu_b/alu_opcode to the alu, alu_result back from it;
//   disp_value/result_valid/overflow to the display; busy during
//   the alu settle window; key_reject pulses for ignored keys.
module calc_sequencer #(
    parameter int ALU_LAT  = 2,
    parameter int DISP_MAX = 999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic signed [7:0]  alu_a,
    output logic signed [7:0]  alu_b,
    output logic [1:0]         alu_opcode,
    input  logic signed [15:0] alu_result,
    output logic signed [15:0] disp_value,
    output logic               busy,
    output logic               result_valid,
    output logic               overflow,
    output logic               key_reject
);

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW
    } state_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    state_t             state_q, state_d;
    logic signed [7:0]  a_q, a_d;
    logic signed [7:0]  b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic signed [15:0] res_q, res_d;
    logic               bh_q, bh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rej_q, rej_d;
    logic signed [15:0] disp_q, disp_d;
    logic               busy_q, busy_d;
    logic               rv_q, rv_d;
    logic               ovf_q, ovf_d;
    logic               zero;

    logic        is_dig, is_op, is_eq;
    logic [1:0]  op_key;
    logic [7:0]  acc_src;
    logic [11:0] acc_nx;
    logic        dig_ok;
    logic        res_fits;

    assign is_dig = (key_code <= 4'd9);
    assign is_op  = (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_eq  = (key_code == 4'd14);
    assign op_key = 2'(key_code - 4'd10);

    // Operands are only ever accumulated from non-negative values,
    // so the unsigned widening is safe.
    assign acc_src = (state_q == ENTER_B) ? b_q : a_q;
    assign acc_nx  = {4'b0, acc_src} * 12'd10 + {8'b0, key_code};
    assign dig_ok  = (acc_nx <= 12'd127);

    assign res_fits = (res_q >= -16'sd128) && (res_q <= 16'sd127);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        bh_d    = bh_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        zero    = 1'b0;
        unique case (state_q)
            ENTER_A: begin
                if (key_valid) begin
                    unique case (1'b1)
                        is_dig: begin
                            if (dig_ok) a_d = acc_nx[7:0];
                            else rej_d = 1'b1;
                        end
                        is_op: begin
                            op_d    = op_key;
                            b_d     = '0;
                            bh_d    = 1'b0;
                            state_d = ENTER_B;
                        end
                        is_eq:   rej_d = 1'b1;
                        default: zero  = 1'b1;
                    endcase
                end
            end
            ENTER_B: begin
                if (key_valid) begin
                    unique case (1'b1)
                        is_dig: begin
                            if (dig_ok) begin
                                b_d  = acc_nx[7:0];
                                bh_d = 1'b1;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        is_op: begin
                            if (bh_q) rej_d = 1'b1;
                            else op_d = op_key;
                        end
                        is_eq: begin
                            if (bh_q) begin
                                state_d = EXEC;
                                cnt_d   = '0;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        default: zero = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                if (key_valid && key_code == 4'd15) begin
                    zero = 1'b1;
                end else begin
                    rej_d = key_valid;
                    if (cnt_q == CNT_LAST) begin
                        res_d   = alu_result;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SHOW: begin
                if (key_valid) begin
                    unique case (1'b1)
                        is_dig: begin
                            a_d     = {4'b0, key_code};
                            state_d = ENTER_A;
                        end
                        is_op: begin
                            if (res_fits) begin
                                a_d     = res_q[7:0];
                                op_d    = op_key;
                                b_d     = '0;
                                bh_d    = 1'b0;
                                state_d = ENTER_B;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        is_eq: begin
                            // Repeat-equals: B and opcode are reused.
                            if (res_fits) begin
                                a_d     = res_q[7:0];
                                cnt_d   = '0;
                                state_d = EXEC;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        default: zero = 1'b1;
                    endcase
                end
            end
        endcase
        if (zero) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            bh_d    = 1'b0;
            cnt_d   = '0;
        end
    end

    // Display-side outputs are computed from the next state so the
    // registered copies line up with the state register.
    always_comb begin
        disp_d = disp_q;
        unique case (state_d)
            ENTER_A: disp_d = {{8{a_d[7]}}, a_d};
            ENTER_B: begin
                if (bh_d) disp_d = {{8{b_d[7]}}, b_d};
                else disp_d = {{8{a_d[7]}}, a_d};
            end
            SHOW:    disp_d = res_d;
            default: disp_d = disp_q;
        endcase
        busy_d = (state_d == EXEC);
        rv_d   = (state_d == SHOW);
        ovf_d  = (state_d == SHOW) &&
                 ((int'(res_d) > DISP_MAX) ||
                  (int'(res_d) < -DISP_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            bh_q    <= 1'b0;
            cnt_q   <= '0;
            rej_q   <= 1'b0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            bh_q    <= bh_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_opcode   = op_q;
    assign disp_value   = disp_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign overflow     = ovf_q;
    assign key_reject   = rej_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a
// behavioural calculator model and a simple combinational alu.
module tb_calc_sequencer;

    localparam int ALU_LAT = 2;
    localparam int DMAX    = 999;
    localparam int M_A = 0, M_B = 1, M_X = 2, M_S = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               key_valid;
    logic [3:0]         key_code;
    logic signed [7:0]  alu_a, alu_b;
    logic [1:0]         alu_opcode;
    logic signed [15:0] alu_result;
    logic signed [15:0] disp_value;
    logic               busy, result_valid, overflow, key_reject;

    calc_sequencer #(.ALU_LAT(ALU_LAT), .DISP_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_code(key_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .disp_value(disp_value),
        .busy(busy), .result_valid(result_valid),
        .overflow(overflow), .key_reject(key_reject)
    );

    always #5 clk = ~clk;

    function automatic int alu_f(int a, int b, int op);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    always_comb alu_result = 16'(alu_f(int'(alu_a), int'(alu_b),
                                       int'(alu_opcode)));

    typedef struct {
        int cyc;
        int val;
    } res_t;

    typedef struct {
        int cyc;
        int a, b, op, disp;
        bit dcare, bsy, rv, ovf;
    } snap_t;

    res_t  rq[$];
    snap_t sq[$];
    int    jq[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural calculator state.
    int mode, mA, mB, mop, mres, mbh, m_e, m_pend;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic void m_zero();
        mode = M_A; mA = 0; mB = 0; mop = 0; mres = 0; mbh = 0;
    endfunction

    function automatic void m_resolve(int c);
        if (mode == M_X && c > m_e + ALU_LAT) begin
            mode = M_S;
            mres = m_pend;
        end
    endfunction

    function automatic void m_exec(int k);
        mode   = M_X;
        m_e    = k;
        m_pend = alu_f(mA, mB, mop);
        rq.push_back('{k + ALU_LAT + 1, m_pend});
    endfunction

    // Apply a key driven in cycle k (sampled at the following edge)
    // and queue everything the DUT should show for it.
    function automatic void m_key(int code, int k);
        bit rej = 0;
        bit fits;
        snap_t s;
        int n;
        m_resolve(k);
        fits = (mres >= -128 && mres <= 127);
        case (mode)
            M_A: begin
                if (code <= 9) begin
                    n = mA * 10 + code;
                    if (n > 127) rej = 1; else mA = n;
                end else if (code <= 13) begin
                    mop = code - 10; mB = 0; mbh = 0; mode = M_B;
                end else if (code == 14) rej = 1;
                else m_zero();
            end
            M_B: begin
                if (code <= 9) begin
                    n = mB * 10 + code;
                    if (n > 127) rej = 1;
                    else begin mB = n; mbh = 1; end
                end else if (code <= 13) begin
                    if (mbh != 0) rej = 1; else mop = code - 10;
                end else if (code == 14) begin
                    if (mbh != 0) m_exec(k); else rej = 1;
                end else m_zero();
            end
            M_X: begin
                if (code == 15) begin
                    void'(rq.pop_back());
                    m_zero();
                end else rej = 1;
            end
            default: begin
                if (code <= 9) begin
                    mA = code; mode = M_A;
                end else if (code <= 13) begin
                    if (fits) begin
                        mA = mres; mop = code - 10;
                        mB = 0; mbh = 0; mode = M_B;
                    end else rej = 1;
                end else if (code == 14) begin
                    if (fits) begin mA = mres; m_exec(k); end
                    else rej = 1;
                end else m_zero();
            end
        endcase
        if (rej) jq.push_back(k + 1);
        m_resolve(k + 1);
        s.cyc   = k + 1;
        s.a     = mA;
        s.b     = mB;
        s.op    = mop;
        s.dcare = (mode == M_X);
        s.disp  = (mode == M_S) ? mres :
                  (mode == M_B && mbh != 0) ? mB : mA;
        s.bsy   = (mode == M_X);
        s.rv    = (mode == M_S);
        s.ovf   = (mode == M_S) && (mres > DMAX || mres < -DMAX);
        sq.push_back(s);
    endfunction

    bit rv_prev = 0;

    always @(negedge clk) begin : mon
        snap_t s;
        res_t  r;
        int    c;
        if (!rst) begin
            if (key_reject) begin
                if (jq.size() == 0) chk("reject_spurious", 1, 0);
                else begin
                    c = jq.pop_front();
                    chk("reject_cycle", cyc, c);
                end
            end
            if (result_valid && !rv_prev) begin
                if (rq.size() == 0) chk("result_spurious", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("result_cycle", cyc, r.cyc);
                    chk("result_value", int'(disp_value), r.val);
                    chk("result_ovf", int'(overflow),
                        int'(r.val > DMAX || r.val < -DMAX));
                end
            end
            if (sq.size() != 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("alu_a", int'(alu_a), s.a);
                chk("alu_b", int'(alu_b), s.b);
                chk("alu_opcode", int'(alu_opcode), s.op);
                chk("busy", int'(busy), int'(s.bsy));
                chk("result_valid", int'(result_valid), int'(s.rv));
                chk("overflow", int'(overflow), int'(s.ovf));
                if (!s.dcare)
                    chk("disp_value", int'(disp_value), s.disp);
            end
        end
        rv_prev = result_valid;
    end

    task automatic key(int code);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = 4'(code);
        m_key(code, cyc);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            key_valid = 1'b0;
        end
    endtask

    task automatic zero_outputs(string tag);
        chk({tag, "_alu_a"}, int'(alu_a), 0);
        chk({tag, "_alu_b"}, int'(alu_b), 0);
        chk({tag, "_opcode"}, int'(alu_opcode), 0);
        chk({tag, "_disp"}, int'(disp_value), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rv"}, int'(result_valid), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_reject"}, int'(key_reject), 0);
    endtask

    initial begin
        int r, g;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        m_zero();
        repeat (2) @(posedge clk);
        #1;
        zero_outputs("reset");
        rst = 1'b0;
        idle(2);

        // 9 + 8 = 17
        key(9); key(10); key(8); key(14); idle(6);
        key(15); idle(2);
        // 128 is out of range, A stays 12
        key(1); key(2); key(8); idle(2);
        key(15); idle(2);
        // 120 * 100 overflows the display; op then rejected
        key(1); key(2); key(0); key(12);
        key(1); key(0); key(0); key(14); idle(5);
        key(10); idle(2); key(5); idle(2);
        key(15); idle(2);
        // chaining: 9-8=1, repeat = gives -7, then *3 = -21
        key(9); key(11); key(8); key(14); idle(5);
        key(14); idle(5);
        key(12); key(3); key(14); idle(5);
        key(15); idle(2);
        // clear immediately after equals aborts the capture
        key(4); key(10); key(5); key(14); key(15); idle(5);
        // stray keys during EXEC are rejected
        key(7); key(11); key(2); key(14); key(3); key(12); idle(5);
        key(15); idle(2);

        // async reset in the middle of a cycle while B=45
        key(4); key(10); key(4); key(5); idle(1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        zero_outputs("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        sq.delete(); jq.delete(); rq.delete();
        m_zero();
        key(3); idle(2);
        chk("after_rst_a", int'(alu_a), 3);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) key($urandom_range(0, 9));
            else if (r < 70) key(10 + $urandom_range(0, 3));
            else if (r < 94) key(14);
            else key(15);
            g = $urandom_range(0, 9);
            idle(g < 6 ? g % 3 : ALU_LAT + 1);
        end
        idle(ALU_LAT + 4);

        chk("pending_snapshots", sq.size(), 0);
        chk("pending_rejects", jq.size(), 0);
        chk("pending_results", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
